// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, NOP encoding, immediate formats.
// Helpers map an opcode to its immediate format and legality.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic imm_type_e imm_type(input logic [6:0] op);
        imm_type_e t;
        t = IMM_NONE;
        unique case (1'b1)
            (op == OP_IMM),
            (op == OP_LOAD),
            (op == OP_JALR):   t = IMM_I;
            (op == OP_STORE):  t = IMM_S;
            (op == OP_BRANCH): t = IMM_B;
            (op == OP_LUI),
            (op == OP_AUIPC):  t = IMM_U;
            (op == OP_JAL):    t = IMM_J;
            default:           t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic is_rv32i(input logic [31:0] instr);
        logic [6:0] op;
        logic       known;
        op    = instr[6:0];
        known = (op == OP_LUI)    || (op == OP_AUIPC)  ||
                (op == OP_JAL)    || (op == OP_JALR)   ||
                (op == OP_BRANCH) || (op == OP_LOAD)   ||
                (op == OP_STORE)  || (op == OP_IMM)    ||
                (op == OP_REG)    || (op == OP_FENCE)  ||
                (op == OP_SYSTEM);
        return known && (instr[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate generator (I/S/B/U/J formats).
// Shared by the fetch buffer, decode and the branch unit.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    imm_type_e ty;

    assign ty = imm_type(instr_i[6:0]);

    // Assemble the sign-extended immediate for the decoded format
    always_comb begin
        imm_o = '0;
        unique case (ty)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25],
                            instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31],
                            instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31],
                            instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID decoupling FIFO with pre-extracted decode fields and flush.
// Optional macro ILLEGAL_CHECK_EN adds the id_illegal output.
module if_id_buffer
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
`ifdef ILLEGAL_CHECK_EN
    output logic            id_illegal,
`endif
    output logic [XLEN-1:0] id_imm
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic            push, pop;

    assign if_ready = (count_q != CW'(DEPTH));
    assign id_valid = (count_q != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    // Next pointers and occupancy; flush empties the FIFO outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset fills every slot with pc 0 and a NOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= NOP_INSTR;
            end
        end else if (push) begin
            pc_q[wr_ptr_q]    <= if_pc;
            instr_q[wr_ptr_q] <= if_instr;
        end
    end

    assign id_pc     = pc_q[rd_ptr_q];
    assign id_instr  = instr_q[rd_ptr_q];
    assign id_opcode = id_instr[6:0];
    assign id_rd     = id_instr[11:7];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];

    riscv_imm_gen u_imm (
        .instr_i (id_instr),
        .imm_o   (id_imm)
    );

`ifdef ILLEGAL_CHECK_EN
    assign id_illegal = id_valid & ~is_rv32i(id_instr);
`endif

endmodule
